// File: rtl/ram_burst_arbiter_if.sv
// rtl/ram_burst_arbiter_if.sv - requester, completion and RAM-port signal bundle for ram_burst_arbiter
interface ram_burst_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 6
);
   logic              req_0;
   logic              req_1;
   logic              we_0;
   logic              we_1;
   logic [ADDR_W-1:0] addr_0;
   logic [ADDR_W-1:0] addr_1;
   logic [LEN_W-1:0]  len_0;
   logic [LEN_W-1:0]  len_1;
   logic [DATA_W-1:0] wdata_0;
   logic [DATA_W-1:0] wdata_1;
   logic              gnt_0;
   logic              gnt_1;
   logic              beat_0;
   logic              beat_1;
   logic [DATA_W-1:0] rdata_0;
   logic [DATA_W-1:0] rdata_1;
   logic              rvalid_0;
   logic              rvalid_1;
   logic              done_0;
   logic              done_1;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy;

   // Arbiter side
   modport slave (
      input  req_0, req_1, we_0, we_1, addr_0, addr_1, len_0, len_1,
      input  wdata_0, wdata_1, ram_rdata,
      output gnt_0, gnt_1, beat_0, beat_1, rdata_0, rdata_1,
      output rvalid_0, rvalid_1, done_0, done_1,
      output ram_en, ram_we, ram_addr, ram_wdata, busy
   );

   // Requesters plus the RAM port they share
   modport master (
      output req_0, req_1, we_0, we_1, addr_0, addr_1, len_0, len_1,
      output wdata_0, wdata_1, ram_rdata,
      input  gnt_0, gnt_1, beat_0, beat_1, rdata_0, rdata_1,
      input  rvalid_0, rvalid_1, done_0, done_1,
      input  ram_en, ram_we, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/ram_burst_arbiter.sv
// rtl/ram_burst_arbiter.sv - two-requester burst arbiter/sequencer for one RAM port; define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins)
module ram_burst_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 6
) (
   input logic                clk,
   input logic                rst,
   ram_burst_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_owner;
   logic              r_last_owner;
   logic              r_cur_we;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [LEN_W-1:0]  r_remaining;
   logic              r_gnt;
   logic              r_done;
   logic              r_rvalid;
   logic              r_ram_en;

   logic              w_any_req;
   logic              w_sel;
   logic [DATA_W-1:0] w_wdata;

   assign w_any_req = bus.req_0 | bus.req_1;

   // Pick the requester that will own the next burst
   always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      w_sel = ~bus.req_0;
`else
      if (bus.req_0 && bus.req_1) begin
         w_sel = ~r_last_owner;
      end else begin
         w_sel = ~bus.req_0;
      end
`endif
   end

   // Burst sequencer: IDLE -> GRANT -> BURST (one beat per cycle) -> DONE -> IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_cur_we     <= 1'b0;
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_gnt        <= 1'b0;
         r_done       <= 1'b0;
         r_rvalid     <= 1'b0;
         r_ram_en     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state      <= S_GRANT;
                  r_owner      <= w_sel;
                  r_last_owner <= w_sel;
                  r_gnt        <= 1'b1;
                  r_cur_we     <= w_sel ? bus.we_1   : bus.we_0;
                  r_cur_addr   <= w_sel ? bus.addr_1 : bus.addr_0;
                  r_remaining  <= w_sel ? bus.len_1  : bus.len_0;
               end
            end
            S_GRANT: begin
               r_gnt <= 1'b0;
               if (r_remaining == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state  <= S_BURST;
                  r_ram_en <= 1'b1;
               end
            end
            S_BURST: begin
               r_cur_addr  <= r_cur_addr + 1'b1;
               r_remaining <= r_remaining - 1'b1;
               // read data returns one cycle behind its beat
               r_rvalid    <= ~r_cur_we;
               if (r_remaining == LEN_W'(1)) begin
                  r_state  <= S_DONE;
                  r_ram_en <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            S_DONE: begin
               r_done   <= 1'b0;
               r_rvalid <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_wdata = r_owner ? bus.wdata_1 : bus.wdata_0;

   assign bus.gnt_0     = r_gnt & ~r_owner;
   assign bus.gnt_1     = r_gnt &  r_owner;
   assign bus.beat_0    = r_ram_en & ~r_owner;
   assign bus.beat_1    = r_ram_en &  r_owner;
   assign bus.done_0    = r_done & ~r_owner;
   assign bus.done_1    = r_done &  r_owner;
   assign bus.rvalid_0  = r_rvalid & ~r_owner;
   assign bus.rvalid_1  = r_rvalid &  r_owner;
   assign bus.rdata_0   = (r_rvalid && !r_owner) ? bus.ram_rdata : '0;
   assign bus.rdata_1   = (r_rvalid &&  r_owner) ? bus.ram_rdata : '0;

   // RAM port is quiet (all zero) outside BURST
   assign bus.ram_en    = r_ram_en;
   assign bus.ram_we    = r_ram_en & r_cur_we;
   assign bus.ram_addr  = r_ram_en ? r_cur_addr : '0;
   assign bus.ram_wdata = r_ram_en ? w_wdata : '0;

   assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_burst_arbiter.sv
// tb/tb_ram_burst_arbiter.sv - randomized and directed self-checking bench for ram_burst_arbiter
module tb_ram_burst_arbiter;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int LW    = 6;
   localparam int DEPTH = 16;
   localparam int NB    = 64;
`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   ram_burst_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

   ram_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   // requester stimulus state
   int          post_cnt [2];
   int          gnt_cnt  [2];
   int          k        [2];
   logic        p_we     [2];
   logic [AW-1:0] p_addr [2];
   logic [LW-1:0] p_len  [2];
   logic [DW-1:0] p_data   [2][NB];
   logic [DW-1:0] cur_data [2][NB];

   // behavioural model state
   bit          m_has = 1'b0;
   int          m_G, m_L, m_A, m_W, m_o;
   int          m_idle = 0;
   int          m_last = 1;
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_bd  [NB];
   int          e_gnt[2], e_beat[2], e_rv[2], e_rd[2], e_done[2];
   int          e_en, e_we, e_addr, e_wd, e_busy;

   // observation logs
   int q_gown[$], q_gcyc[$], q_down[$], q_dcyc[$], q_wa[$], q_rd1[$], q_rc1[$];
   int n_busy = 0;
   int n_en = 0;
   int n_beat0 = 0;

   // environment RAM (the shared dual_port_ram port)
   logic [DW-1:0] env_mem [DEPTH];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic post(input int r, input int we, input int addr, input int len,
                       input int base, input int rnd);
      int t = 0;
      while (post_cnt[r] != gnt_cnt[r] && t < 300) begin
         step(1);
         t++;
      end
      chk("post_ready", int'(post_cnt[r] == gnt_cnt[r]), 1);
      p_we[r]   = we[0];
      p_addr[r] = AW'(addr);
      p_len[r]  = LW'(len);
      for (int i = 0; i < NB; i++) p_data[r][i] = (rnd != 0) ? DW'($urandom) : DW'(base + i);
      post_cnt[r]++;
   endtask

   task automatic wait_quiet(input int budget);
      int t = 0;
      while (!(post_cnt[0] == gnt_cnt[0] && post_cnt[1] == gnt_cnt[1] && cyc > m_idle)
             && t < budget) begin
         step(1);
         t++;
      end
      chk("quiet_timeout", int'(t < budget), 1);
   endtask

   // requester driver: drop req on grant, advance write data on each beat
   initial begin
      bus.req_0 = 1'b0; bus.req_1 = 1'b0; bus.we_0 = 1'b0; bus.we_1 = 1'b0;
      bus.addr_0 = '0; bus.addr_1 = '0; bus.len_0 = '0; bus.len_1 = '0;
      bus.wdata_0 = '0; bus.wdata_1 = '0;
      for (int r = 0; r < 2; r++) begin
         post_cnt[r] = 0; gnt_cnt[r] = 0; k[r] = 0;
         p_we[r] = 1'b0; p_addr[r] = '0; p_len[r] = '0;
         for (int i = 0; i < NB; i++) begin
            p_data[r][i] = '0;
            cur_data[r][i] = '0;
         end
      end
      forever begin
         @(negedge clk);
         #1;
         if (bus.gnt_0) begin
            gnt_cnt[0]++;
            k[0] = 0;
            for (int i = 0; i < NB; i++) cur_data[0][i] = p_data[0][i];
         end else if (bus.beat_0 && k[0] < NB - 1) k[0]++;
         if (bus.gnt_1) begin
            gnt_cnt[1]++;
            k[1] = 0;
            for (int i = 0; i < NB; i++) cur_data[1][i] = p_data[1][i];
         end else if (bus.beat_1 && k[1] < NB - 1) k[1]++;
         bus.req_0   = (post_cnt[0] != gnt_cnt[0]);
         bus.req_1   = (post_cnt[1] != gnt_cnt[1]);
         bus.we_0    = p_we[0];
         bus.we_1    = p_we[1];
         bus.addr_0  = p_addr[0];
         bus.addr_1  = p_addr[1];
         bus.len_0   = p_len[0];
         bus.len_1   = p_len[1];
         bus.wdata_0 = cur_data[0][k[0]];
         bus.wdata_1 = cur_data[1][k[1]];
      end
   end

   // RAM: writes land at the beat, read data appears in the following cycle
   initial begin
      bit            rd_pend;
      logic [DW-1:0] rd_val;
      bus.ram_rdata = '0;
      for (int i = 0; i < DEPTH; i++) env_mem[i] = '0;
      forever begin
         @(negedge clk);
         rd_pend = 1'b0;
         rd_val  = '0;
         if (bus.ram_en) begin
            if (bus.ram_we) env_mem[bus.ram_addr] = bus.ram_wdata;
            else begin
               rd_pend = 1'b1;
               rd_val  = env_mem[bus.ram_addr];
            end
         end
         @(posedge clk);
         #1;
         if (rd_pend) bus.ram_rdata = rd_val;
      end
   end

   // model: arbitrate at each edge, then check every output mid-cycle
   initial begin
      int o;
      int kk;
      int c;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int i = 0; i < NB; i++) m_bd[i] = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_has  = 1'b0;
            m_last = 1;
            m_idle = 0;
         end else if (cyc >= m_idle && (bus.req_0 || bus.req_1)) begin
            if (bus.req_0 && bus.req_1) o = FIXED ? 0 : 1 - m_last;
            else o = bus.req_0 ? 0 : 1;
            m_o    = o;
            m_G    = cyc + 1;
            m_W    = (o == 1) ? int'(bus.we_1) : int'(bus.we_0);
            m_A    = (o == 1) ? int'(bus.addr_1) : int'(bus.addr_0);
            m_L    = (o == 1) ? int'(bus.len_1) : int'(bus.len_0);
            m_last = o;
            m_idle = m_G + m_L + 2;
            m_has  = 1'b1;
            for (int i = 0; i < NB; i++) m_bd[i] = p_data[o][i];
         end
         cyc++;

         @(negedge clk);
         c = cyc;
         for (int r = 0; r < 2; r++) begin
            e_gnt[r] = 0; e_beat[r] = 0; e_rv[r] = 0; e_rd[r] = 0; e_done[r] = 0;
         end
         e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_busy = 0;
         if (m_has && !rst) begin
            if (c == m_G) e_gnt[m_o] = 1;
            if (c >= m_G && c <= m_G + m_L + 1) e_busy = 1;
            if (c >= m_G + 1 && c <= m_G + m_L) begin
               kk           = c - m_G - 1;
               e_beat[m_o]  = 1;
               e_en         = 1;
               e_we         = m_W;
               e_addr       = (m_A + kk) % DEPTH;
               e_wd         = int'(m_bd[kk]);
               if (m_W != 0) m_mem[e_addr] = m_bd[kk];
            end
            if (m_W == 0 && c >= m_G + 2 && c <= m_G + m_L + 1) begin
               e_rv[m_o] = 1;
               e_rd[m_o] = int'(m_mem[(m_A + c - m_G - 2) % DEPTH]);
            end
            if (c == m_G + m_L + 1) e_done[m_o] = 1;
         end
         chk("gnt_0", bus.gnt_0, e_gnt[0]);
         chk("gnt_1", bus.gnt_1, e_gnt[1]);
         chk("beat_0", bus.beat_0, e_beat[0]);
         chk("beat_1", bus.beat_1, e_beat[1]);
         chk("rvalid_0", bus.rvalid_0, e_rv[0]);
         chk("rvalid_1", bus.rvalid_1, e_rv[1]);
         chk("rdata_0", bus.rdata_0, e_rd[0]);
         chk("rdata_1", bus.rdata_1, e_rd[1]);
         chk("done_0", bus.done_0, e_done[0]);
         chk("done_1", bus.done_1, e_done[1]);
         chk("ram_en", bus.ram_en, e_en);
         chk("ram_we", bus.ram_we, e_we);
         chk("ram_addr", bus.ram_addr, e_addr);
         chk("ram_wdata", bus.ram_wdata, e_wd);
         chk("busy", bus.busy, e_busy);

         if (bus.gnt_0) begin q_gown.push_back(0); q_gcyc.push_back(c); end
         if (bus.gnt_1) begin q_gown.push_back(1); q_gcyc.push_back(c); end
         if (bus.done_0) begin q_down.push_back(0); q_dcyc.push_back(c); end
         if (bus.done_1) begin q_down.push_back(1); q_dcyc.push_back(c); end
         if (bus.ram_en && bus.ram_we) q_wa.push_back(int'(bus.ram_addr));
         if (bus.rvalid_1) begin q_rd1.push_back(int'(bus.rdata_1)); q_rc1.push_back(c); end
         if (bus.busy) n_busy++;
         if (bus.ram_en) n_en++;
         if (bus.beat_0) n_beat0++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // directed scenarios followed by random traffic
   initial begin
      int b, g, d, rb, nb, ne, t;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", bus.busy, 0);
      chk("reset_gnt_0", bus.gnt_0, 0);
      chk("reset_ram_en", bus.ram_en, 0);
      #1;
      rst = 1'b0;
      step(2);

      // write 1..16 at 0..15, then read back through requester 1
      b = q_wa.size();
      post(0, 1, 0, 16, 1, 0);
      wait_quiet(200);
      rb = q_rd1.size();
      d  = q_dcyc.size();
      post(1, 0, 0, 16, 0, 1);
      wait_quiet(200);
      chk("wr_beats", q_wa.size() - b, 16);
      if (q_wa.size() - b >= 16)
         for (int i = 0; i < 16; i++) chk("wr_addr_seq", q_wa[b + i], i);
      chk("rd_beats", q_rd1.size() - rb, 16);
      if (q_rd1.size() - rb >= 16) begin
         for (int i = 0; i < 16; i++) chk("readback", q_rd1[rb + i], i + 1);
         chk("rvalid_gapless", q_rc1[rb + 15] - q_rc1[rb], 15);
         if (q_dcyc.size() > d) chk("done_on_last_rvalid", q_dcyc[d], q_rc1[rb + 15]);
      end

      // simultaneous requests, three rounds of len 2
      g = q_gown.size();
      for (int rnd = 0; rnd < 3; rnd++) begin
         post(0, 0, $urandom_range(0, 15), 2, 0, 1);
         post(1, 0, $urandom_range(0, 15), 2, 0, 1);
         wait_quiet(200);
      end
      chk("tie_grants", q_gown.size() - g, 6);
      if (q_gown.size() - g >= 6) begin
         for (int i = 0; i < 6; i++) chk("tie_order", q_gown[g + i], i % 2);
         for (int i = 0; i < 3; i++) chk("tie_gap", q_gcyc[g + 2 * i + 1] - q_gcyc[g + 2 * i], 5);
      end

      // after requester 0 alone, a tie goes to 1 (round-robin) or 0 (fixed)
      g = q_gown.size();
      post(0, 0, 3, 1, 0, 1);
      wait_quiet(100);
      post(0, 0, 4, 1, 0, 1);
      post(1, 0, 5, 1, 0, 1);
      wait_quiet(100);
      chk("prio_grants", q_gown.size() - g, 3);
      if (q_gown.size() - g >= 3) chk("prio_tie_winner", q_gown[g + 1], FIXED ? 0 : 1);

      // wrap-around at the top of the address space
      b = q_wa.size();
      post(0, 1, 14, 4, 8'hA0, 0);
      wait_quiet(100);
      rb = q_rd1.size();
      post(1, 0, 14, 4, 0, 1);
      wait_quiet(100);
      chk("wrap_beats", q_wa.size() - b, 4);
      if (q_wa.size() - b >= 4) begin
         chk("wrap_a0", q_wa[b], 14);
         chk("wrap_a1", q_wa[b + 1], 15);
         chk("wrap_a2", q_wa[b + 2], 0);
         chk("wrap_a3", q_wa[b + 3], 1);
      end
      chk("wrap_reads", q_rd1.size() - rb, 4);
      if (q_rd1.size() - rb >= 4)
         for (int i = 0; i < 4; i++) chk("wrap_readback", q_rd1[rb + i], 8'hA0 + i);

      // zero-length burst
      nb = n_busy; ne = n_en; g = q_gown.size(); d = q_dcyc.size();
      post(1, 0, 5, 0, 0, 1);
      wait_quiet(100);
      chk("zl_busy_cycles", n_busy - nb, 2);
      chk("zl_ram_en_cycles", n_en - ne, 0);
      chk("zl_grants", q_gown.size() - g, 1);
      chk("zl_dones", q_dcyc.size() - d, 1);
      if (q_gown.size() > g && q_dcyc.size() > d) begin
         chk("zl_owner", q_gown[g], 1);
         chk("zl_done_owner", q_down[d], 1);
         chk("zl_done_latency", q_dcyc[d] - q_gcyc[g], 1);
      end

      // reset during beat 5 of a 16-beat write
      b = n_beat0;
      post(0, 1, 0, 16, 8'h30, 0);
      t = 0;
      while (n_beat0 - b < 5 && t < 100) begin
         step(1);
         t++;
      end
      chk("abort_beat5", n_beat0 - b, 5);
      d = q_dcyc.size();
      rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_beat_0", bus.beat_0, 0);
      chk("abort_ram_en", bus.ram_en, 0);
      chk("abort_ram_addr", bus.ram_addr, 0);
      chk("abort_ram_wdata", bus.ram_wdata, 0);
      chk("abort_done_0", bus.done_0, 0);
      step(3);
      chk("abort_no_done", q_dcyc.size() - d, 0);
      rst = 1'b0;
      g = q_gown.size();
      post(0, 0, 1, 1, 0, 1);
      post(1, 0, 2, 1, 0, 1);
      wait_quiet(100);
      chk("post_reset_grants", q_gown.size() - g, 2);
      if (q_gown.size() > g) chk("post_reset_first", q_gown[g], 0);

      // random traffic from both requesters
      for (int i = 0; i < 80; i++) begin
         int r;
         r = $urandom_range(0, 1);
         if (post_cnt[r] == gnt_cnt[r])
            post(r, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 12), 0, 1);
         if ($urandom_range(0, 3) == 0 && post_cnt[1 - r] == gnt_cnt[1 - r])
            post(1 - r, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 12), 0, 1);
         step($urandom_range(0, 4));
      end
      wait_quiet(3000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
